// File: rtl/axis_hit_serializer_pkg.sv
// Shared types and constants for the hit-word serializer: FSM encoding,
// word/beat geometry and the overflow counter ceiling.
package axis_hit_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int          HIT_MASK_W = 66;
  localparam int          BEATS      = 4;
  localparam int          WORD_W     = 128;
  localparam int          BEAT_W     = WORD_W / BEATS;
  localparam int          BEAT_CNT_W = $clog2(BEATS);
  localparam logic [15:0] OVFL_MAX   = 16'hFFFF;

endpackage

// File: rtl/axis_hit_fifo.sv
// Circular word buffer: 2**DEPTH_LOG2 entries, wrapping read/write pointers
// and a separate occupancy counter. The caller never pushes when full.
module axis_hit_fifo
  import axis_hit_serializer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push,
  input  logic [WORD_W-1:0]     i_wdata,
  input  logic                  i_pop,
  output logic [WORD_W-1:0]     o_head,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_full
);

  localparam int                DEPTH   = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [WORD_W-1:0]     r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;

  // NOTE: storage has no reset; only pointers and occupancy decide what is valid.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;
  assign o_full  = (r_level == LVL_FULL);

endmodule

// File: rtl/axis_hit_serializer.sv
// Captures 128-bit hit words (optional zero-mask filter, drop-on-full with a
// saturating counter) and serializes each into four 32-bit AXI-Stream beats.
module axis_hit_serializer
  import axis_hit_serializer_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [1:0]            cfg,
  input  logic [WORD_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic [BEAT_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           sts_ovfl,
  output logic [DEPTH_LOG2:0]   sts_level
);

  localparam logic [DEPTH_LOG2:0]   LVL_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [BEAT_CNT_W-1:0] BEAT_LAST = BEAT_CNT_W'(BEATS - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [BEAT_CNT_W-1:0] r_beat;
  logic [15:0]           r_ovfl;

  logic                  w_filtered;
  logic                  w_push;
  logic                  w_drop;
  logic                  w_pop;
  logic                  w_beat_done;
  logic                  w_full;
  logic [WORD_W-1:0]     w_head;
  logic [DEPTH_LOG2:0]   w_level;

  assign w_filtered  = cfg[0] && (s_axis_tdata[HIT_MASK_W-1:0] == '0);
  assign w_push      = s_axis_tvalid && !w_filtered && !w_full;
  assign w_drop      = s_axis_tvalid && !w_filtered && w_full;
  assign w_beat_done = m_axis_tvalid && m_axis_tready;
  assign w_pop       = w_beat_done && m_axis_tlast;

  axis_hit_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk   (aclk),
    .i_rst   (areset),
    .i_push  (w_push),
    .i_wdata (s_axis_tdata),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (w_level),
    .o_full  (w_full)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      // Leaving on the capture edge itself gives tvalid one cycle after the write.
      IDLE: if (w_level != '0 || w_push) w_state_nxt = SEND;
      SEND: if (w_pop && w_level == LVL_ONE && !w_push) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_beat <= '0;
    end else if (w_beat_done) begin
      r_beat <= m_axis_tlast ? '0 : r_beat + 1'b1;
    end
  end

  // Clear wins over increment; the counter sticks at its ceiling.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_ovfl <= '0;
    end else if (cfg[1]) begin
      r_ovfl <= '0;
    end else if (w_drop && r_ovfl != OVFL_MAX) begin
      r_ovfl <= r_ovfl + 1'b1;
    end
  end

  assign m_axis_tvalid = (r_state == SEND);
  assign m_axis_tlast  = m_axis_tvalid && (r_beat == BEAT_LAST);
  assign m_axis_tdata  = m_axis_tvalid ? w_head[r_beat * BEAT_W +: BEAT_W] : '0;
  assign sts_ovfl      = r_ovfl;
  assign sts_level     = w_level;

endmodule

// File: tb/tb_axis_hit_serializer.sv
// Directed bench for axis_hit_serializer: expected beats are queued when
// words are driven and compared as the DUT presents them.
module tb_axis_hit_serializer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic         aclk          = 1'b0;
  logic         areset        = 1'b1;
  logic [1:0]   cfg           = 2'b00;
  logic [127:0] s_axis_tdata  = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         m_axis_tready = 1'b0;
  logic [31:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tlast;
  logic [15:0]  sts_ovfl;
  logic [2:0]   sts_level;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t sb[$];

  axis_hit_serializer #(.DEPTH_LOG2(2)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .cfg           (cfg),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sts_ovfl      (sts_ovfl),
    .sts_level     (sts_level)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one word for exactly one capture edge; returns at the next negedge.
  task automatic put(input logic [127:0] w);
    s_axis_tdata  = w;
    s_axis_tvalid = 1'b1;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
  endtask

  task automatic exp_word(input logic [127:0] w);
    for (int b = 0; b < 4; b++) begin
      beat_t e;
      e.data = w[32*b +: 32];
      e.last = (b == 3);
      sb.push_back(e);
    end
  endtask

  // Observe at each negedge; a beat is consumed when valid & ready at the next edge.
  task automatic run_out(input int cycles, input bit toggle);
    for (int c = 0; c < cycles; c++) begin
      m_axis_tready = toggle ? (c % 2 == 0) : 1'b1;
      if (sb.size() != 0) begin
        check("tvalid_pending", m_axis_tvalid, 1'b1);
        check("tdata", m_axis_tdata, sb[0].data);
        check("tlast", m_axis_tlast, sb[0].last);
        if (m_axis_tvalid && m_axis_tready) void'(sb.pop_front());
      end else begin
        check("tvalid_idle", m_axis_tvalid, 1'b0);
      end
      @(negedge aclk);
    end
    m_axis_tready = 1'b0;
    check("sb_drained", sb.size(), 0);
  endtask

  initial begin
    logic [127:0] w;
    logic [127:0] wa;
    logic [127:0] wb;
    logic [127:0] wz;

    // Reset state
    #1;
    check("rst_tvalid", m_axis_tvalid, 1'b0);
    check("rst_tlast", m_axis_tlast, 1'b0);
    check("rst_tdata", m_axis_tdata, 32'h0);
    check("rst_ovfl", sts_ovfl, 16'h0);
    check("rst_level", sts_level, 3'd0);
    @(negedge aclk);
    areset = 1'b0;

    // Single word, continuous ready: beats 1..4 starting one cycle after capture
    w = 128'h0000_0004_0000_0003_0000_0002_0000_0001;
    m_axis_tready = 1'b1;
    put(w);
    exp_word(w);
    run_out(7, 1'b0);
    check("t1_level", sts_level, 3'd0);

    // Zero-mask filter on, then off
    wz = {62'h1234_5678_9ABC, 66'h0};
    cfg = 2'b01;
    m_axis_tready = 1'b1;
    put(wz);
    check("flt_tvalid", m_axis_tvalid, 1'b0);
    repeat (3) @(negedge aclk);
    check("flt_tvalid_late", m_axis_tvalid, 1'b0);
    check("flt_ovfl", sts_ovfl, 16'h0);
    check("flt_level", sts_level, 3'd0);
    cfg = 2'b00;
    m_axis_tready = 1'b0;
    put(wz);
    exp_word(wz);
    run_out(8, 1'b0);

    // Six words into a four-deep buffer while stalled
    m_axis_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      w = {$urandom, $urandom, $urandom, $urandom};
      w[0] = 1'b1;
      put(w);
      if (i < 4) exp_word(w);
    end
    check("full_level", sts_level, 3'd4);
    check("full_ovfl", sts_ovfl, 16'd2);
    run_out(24, 1'b0);
    check("full_level_after", sts_level, 3'd0);

    // Ready toggling during a word
    w = 128'hDDDD_0004_CCCC_0003_BBBB_0002_AAAA_0001;
    put(w);
    exp_word(w);
    run_out(12, 1'b1);

    // Reset in the middle of a word with two words buffered
    wa = 128'h1111_0004_1111_0003_1111_0002_1111_0001;
    wb = 128'h2222_0004_2222_0003_2222_0002_2222_0001;
    m_axis_tready = 1'b0;
    put(wa);
    put(wb);
    check("mid_level", sts_level, 3'd2);
    m_axis_tready = 1'b1;
    @(negedge aclk);
    m_axis_tready = 1'b0;
    check("mid_beat1", m_axis_tdata, 32'h1111_0002);
    #2 areset = 1'b1;
    #1;
    check("mid_rst_tvalid", m_axis_tvalid, 1'b0);
    check("mid_rst_tdata", m_axis_tdata, 32'h0);
    check("mid_rst_tlast", m_axis_tlast, 1'b0);
    check("mid_rst_level", sts_level, 3'd0);
    @(negedge aclk);
    areset = 1'b0;
    w = 128'h3333_0004_3333_0003_3333_0002_3333_0001;
    put(w);
    exp_word(w);
    run_out(8, 1'b0);

    // Overflow counter saturation and clear priority
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w = {32'(i), 32'h5555_0000, 32'h6666_0000, 32'h7777_0000 + 32'(i)};
      put(w);
      exp_word(w);
    end
    check("sat_level", sts_level, 3'd4);
    check("sat_ovfl_start", sts_ovfl, 16'h0);
    s_axis_tdata  = 128'h1;
    s_axis_tvalid = 1'b1;
    repeat (65534) @(negedge aclk);
    check("sat_ovfl_fffe", sts_ovfl, 16'hFFFE);
    @(negedge aclk);
    check("sat_ovfl_ffff", sts_ovfl, 16'hFFFF);
    repeat (3) @(negedge aclk);
    check("sat_ovfl_hold", sts_ovfl, 16'hFFFF);
    cfg = 2'b10;
    @(negedge aclk);
    check("clr_ovfl", sts_ovfl, 16'h0);
    cfg = 2'b00;
    @(negedge aclk);
    check("clr_then_drop", sts_ovfl, 16'h1);
    s_axis_tvalid = 1'b0;
    check("sat_level_after", sts_level, 3'd4);
    run_out(24, 1'b0);
    check("final_level", sts_level, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axis_hit_serializer.md
AXIS_HIT_SERIALIZER -- requirements
Module: axis_hit_serializer

Interface
REQ-001 Parameter DEPTH_LOG2, default 2, sets the word buffer depth to 2**DEPTH_LOG2 entries of 128 bits.
REQ-002 aclk  input  1  single clock; all logic on rising edge.
REQ-003 areset  input  1  reset, asynchronous and active-high.
REQ-004 cfg  input  2  bit0 = zero-mask filter enable; bit1 = clear overflow counter (level).
REQ-005 s_axis_tdata  input  128  windowed word; [65:0] hit mask, [127:66] timestamp/tag.
REQ-006 s_axis_tvalid  input  1  word valid; no tready, the upstream cannot be stalled.
REQ-007 m_axis_tdata  output  32  serialized beat.
REQ-008 m_axis_tvalid  output  1  beat valid.
REQ-009 m_axis_tready  input  1  downstream ready.
REQ-010 m_axis_tlast  output  1  high on the 4th beat of each word.
REQ-011 sts_ovfl  output  16  count of words dropped because the buffer was full.
REQ-012 sts_level  output  DEPTH_LOG2+1  current buffer occupancy.

Function
REQ-013 Capture: on a cycle with s_axis_tvalid=1, the word SHALL be written to the buffer unless dropped.
REQ-014 Filter: with cfg[0]=1, a word with s_axis_tdata[65:0]==0 SHALL be discarded silently, with no write and no overflow count.
REQ-015 Full: if occupancy equals 2**DEPTH_LOG2 at the capture edge, the word SHALL be dropped and sts_ovfl incremented, even when a pop occurs on the same edge.
REQ-016 sts_ovfl SHALL saturate at 16'hFFFF and SHALL be held at 0 while cfg[1]=1; clear has priority over increment.
REQ-017 Buffer is a circular FIFO with DEPTH_LOG2-bit read/write pointers wrapping modulo depth; occupancy is a separate counter.
REQ-018 Simultaneous push and pop SHALL leave occupancy unchanged.
REQ-019 FSM states: IDLE, SEND.
REQ-020 IDLE -> SEND when occupancy != 0; m_axis_tvalid SHALL rise the cycle after the first word is written (1-cycle latency).
REQ-021 In SEND, a 2-bit beat counter b selects m_axis_tdata = head[32*b+31:32*b] (beat 0 = bits 31:0).
REQ-022 A beat completes only when m_axis_tvalid & m_axis_tready; tdata, tlast and tvalid SHALL stay stable while tready=0.
REQ-023 On completion of beat 3 (tlast=1), the head SHALL pop and b SHALL return to 0; the FSM stays in SEND if occupancy after the pop is non-zero (back-to-back words, no bubble), otherwise it goes to IDLE.
REQ-024 Throughput: 1 beat per cycle under continuous tready, i.e. a sustained input of at most 1 word per 4 cycles without loss.
REQ-025 m_axis_tvalid SHALL be 0 in IDLE.

Reset
REQ-026 areset assertion SHALL immediately (asynchronously) force: FSM=IDLE, b=0, pointers=0, occupancy=0, sts_ovfl=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-027 Reset mid-word SHALL abandon the word in progress and all buffered words; no partial word is emitted after release.
REQ-028 Buffer RAM contents are not reset; first capture is allowed on the first edge after deassertion.

Structure
REQ-029 A shared package SHALL hold the FSM state encoding (IDLE=0, SEND=1), the hit-mask width constant 66 and the beat count constant 4.
REQ-030 The FIFO storage plus pointers/occupancy SHALL be one sub-module, axis_hit_fifo; the FSM, filter, serializer mux and counters live in the top.

Verification
REQ-031 Single word 128'h0000_0004_0000_0003_0000_0002_0000_0001, tready=1 -> beats 1,2,3,4 on 4 consecutive cycles starting 1 cycle after capture; tlast only on the beat with data 4.
REQ-032 cfg[0]=1, word with [65:0]=0 -> no output, sts_ovfl=0, sts_level=0; same word with cfg[0]=0 -> 4 beats out.
REQ-033 DEPTH_LOG2=2, tready=0, 6 nonzero words -> sts_level=4, sts_ovfl=2; then tready=1 -> exactly 16 beats, first 4 words in order.
REQ-034 tready toggling 1,0,1,0 during a word -> each beat held stable while stalled, 4 beats total, no duplicates.
REQ-035 areset pulse after beat 1 with 2 words buffered -> tvalid=0 immediately, sts_level=0; next captured word starts at beat 0.
REQ-036 sts_ovfl preset to 16'hFFFF via overflow -> further drops keep 16'hFFFF; cfg[1]=1 for one cycle -> 0.
